bsm_fetch_sequencer: RTL
========================

// Module: bsm_fetch_sequencer
// PURPOSE
//  Sequential replacement for the all-parallel background path. Once per scanline it walks the
//  32 nametable columns over a single-port VRAM and writes one 19-bit Background Scanline Memory
//  (BSM) entry per column. CPU VRAM writes share the same port and have strict priority.
//  Sits between the CPU bus and VRAM; the pixel pipeline reads the BSM during the visible line.
// PARAMETERS
//  VRAM_ADDR_WIDTH  12       VRAM address width (PMF+PMB+NTBL+OBM = 2304 bytes)
//  PMB_BASE         12'h200  byte address of PMB[0]
//  NTBL_BASE        12'h400  byte address of NTBL[0]; colour byte is at NTBL_BASE+960
// PORTS
//  clk          in   1    pixel clock, 12.5875 MHz
//  rst          in   1    asynchronous, active-low reset
//  line_start   in   1    1-cycle pulse: start fetching the line given by line_y
//  line_y       in   8    y of the line to fetch; sampled when line_start=1
//  busy         out  1    fetch in progress
//  done         out  1    1-cycle pulse when the column-31 entry has been written
//  cpu_cs       in   1    CPU write request; granted in the same cycle
//  cpu_addr     in   VRAM_ADDR_WIDTH  CPU write address
//  cpu_data     in   8    CPU write data
//  vram_addr    out  VRAM_ADDR_WIDTH  shared VRAM address
//  vram_wdata   out  8    VRAM write data (= cpu_data)
//  vram_we      out  1    VRAM write strobe
//  vram_re      out  1    fetcher read strobe
//  vram_rdata   in   8    read data; valid the cycle after vram_re=1
//  bsm_we       out  1    BSM write strobe
//  bsm_col      out  5    BSM column index
//  bsm_wdata    out  19   {colour[2:0], line[15:0]}; pixel 0 in bits [15:14]
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, all latches 0. vram_we is gated to 0 while rst=0.
//  Port mux (combinational):
//   - cpu_cs=1: vram_we=1, vram_addr=cpu_addr, vram_re=0.
//   - cpu_cs=0: vram_addr=fetch_addr; vram_re=1 in issue states.
//   - An "owned" cycle is an issue-state cycle with cpu_cs=0. The FSM advances only on owned
//     cycles; otherwise it holds state and address (stall).
//  Read data: for a read owned at cycle t, vram_rdata is latched at t+1 whether or not t+1 is
//   owned, so a stall never loses read data.
//  Addressing: r=line_y[7:3], ty=line_y[2:0].
//   - NTBL address = NTBL_BASE + {r, c[4:0]}.
//   - PMB address = PMB_BASE + {pmba[4:0], ty', b}, with b=0 for the high byte (bits [15:8]).
//  FSM states (issue address, then capture):
//   - IDLE: on line_start, latch line_y, set c=0, busy=1, go to COL.
//   - COL: issue NTBL_BASE+960, go to TILE.
//   - TILE: capture colours; issue the NTBL tile address, go to PLO.
//   - PLO: capture tile byte; issue PMB byte b=0, go to PHI.
//   - PHI: capture byte0; issue PMB byte b=1, go to WR.
//   - WR (not an issue state; never stalls):
//     * capture byte1; bsm_we=1, bsm_col=c.
//     * colour = tile[7] ? colours[5:3] : colours[2:0].
//     * If c=31: done=1, busy=0, go to IDLE. Else c=c+1, go to TILE.
//  Latency: with no CPU traffic, 2 + 32*4 = 130 cycles from line_start to done (inclusive of the
//   WR cycle). Each stalled cycle adds 1.
//  bsm_we, done: asserted only in WR; 0 otherwise.
//  line_start while busy: abort, re-latch line_y, set c=0, go to COL. No done pulse for the
//   aborted line. BSM entries already written stay written.
//  line_start and cpu_cs in the same cycle: the CPU write proceeds and the fetch starts (COL is
//   entered next cycle).
//  Mid-operation reset: immediate IDLE, outputs 0. A partial BSM line is left as written.
//  Colours are re-read every line; a CPU write to NTBL_BASE+960 during a fetch affects the next
//   line only.
// CONFIGURATION
//  BSM_FETCH_FLIP_EN defined:
//   - ty' = tile[5] ? 7-ty : ty (vflip).
//   - tile[6]=1 reverses the order of the eight 2-bit pixels in line[15:0] (hflip).
//  BSM_FETCH_FLIP_EN undefined: ty'=ty, line={byte0, byte1}; tile[6:5] are ignored.
// TESTING
//  - Reset: rst=0 mid-fetch -> busy=0, bsm_we=0, vram_we=0; after release stays IDLE until line_start.
//  - Idle line: NTBL[960]=8'h0A, NTBL tile(2,c)={c[0],2'b00,c}, line_y=8'd19 -> 32 BSM writes cols 0..31; done exactly 130 cycles after line_start; odd cols colour 3'b001, even 3'b010.
//  - Arbitration: cpu_cs=1 for 5 cycles at line_start+10 -> those writes hit VRAM unchanged; done at +135; BSM data identical to the no-traffic run.
//  - Restart: line_start with line_y=8 at +50, then line_y=16 -> only one done, at +50+130; bsm_wdata matches row 2.
//  - Flip (BSM_FETCH_FLIP_EN): tile 8'h60, PMB bytes for ty'=7 = 16'h1B00, ty=0 -> line=16'h00E4; without macro -> PMB row 0 raw.
//  - Stall on WR-adjacent read: cpu_cs held during PHI -> byte0 still latched correctly, no BSM corruption.

Source files
------------

// File: rtl/bsm_fetch_sequencer.sv
// bsm_fetch_sequencer: per-scanline sequential nametable/PMB fetch into the BSM over a CPU-priority single-port VRAM.
// Define BSM_FETCH_FLIP_EN to enable per-tile vertical (tile[5]) and horizontal (tile[6]) flip.
module bsm_fetch_sequencer #(
  parameter int VRAM_ADDR_WIDTH = 12,
  parameter logic [VRAM_ADDR_WIDTH-1:0] PMB_BASE = 'h200,
  parameter logic [VRAM_ADDR_WIDTH-1:0] NTBL_BASE = 'h400
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       line_start,
  input  logic [7:0]                 line_y,
  output logic                       busy,
  output logic                       done,
  input  logic                       cpu_cs,
  input  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]                 cpu_data,
  output logic [VRAM_ADDR_WIDTH-1:0] vram_addr,
  output logic [7:0]                 vram_wdata,
  output logic                       vram_we,
  output logic                       vram_re,
  input  logic [7:0]                 vram_rdata,
  output logic                       bsm_we,
  output logic [4:0]                 bsm_col,
  output logic [18:0]                bsm_wdata
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_COL  = 3'd1;
  localparam logic [2:0] S_TILE = 3'd2;
  localparam logic [2:0] S_PLO  = 3'd3;
  localparam logic [2:0] S_PHI  = 3'd4;
  localparam logic [2:0] S_WR   = 3'd5;
  logic [2:0] state_q, state_d;
  logic [4:0] c_q, c_d;
  logic [7:0] line_q, line_d;
  logic [5:0] clr_q, clr_d;
  logic       pal_q, pal_d;
  logic [4:0] pmba_q, pmba_d;
  logic [7:0] b0_q, b0_d;
  logic       rd_pend_q, rd_pend_d;
  logic       issue, owned, cpu_g, tile_cap;
  logic [4:0] pmba_v;
  logic [2:0] ty_v;
  logic [15:0] pix, pix_o;
  logic [2:0] colour;
  logic [VRAM_ADDR_WIDTH-1:0] fetch_addr;
`ifdef BSM_FETCH_FLIP_EN
  logic vf_q, vf_d, hf_q, hf_d, vf_v;
`endif
  always_comb begin
    cpu_g    = cpu_cs & rst;
    issue    = (state_q == S_COL) || (state_q == S_TILE) || (state_q == S_PLO) || (state_q == S_PHI);
    owned    = issue & ~cpu_cs;
    // The tile byte arrives in the first PLO cycle; forward it so PLO can issue without waiting.
    tile_cap = (state_q == S_PLO) && rd_pend_q;
    pmba_v   = tile_cap ? vram_rdata[4:0] : pmba_q;
`ifdef BSM_FETCH_FLIP_EN
    vf_v     = tile_cap ? vram_rdata[5] : vf_q;
    ty_v     = vf_v ? ~line_q[2:0] : line_q[2:0];
`else
    ty_v     = line_q[2:0];
`endif
    fetch_addr = (state_q == S_COL)  ? NTBL_BASE + VRAM_ADDR_WIDTH'(960) :
                 (state_q == S_TILE) ? NTBL_BASE + VRAM_ADDR_WIDTH'({line_q[7:3], c_q}) :
                 (state_q == S_PLO || state_q == S_PHI) ?
                   PMB_BASE + VRAM_ADDR_WIDTH'({pmba_v, ty_v, state_q == S_PHI}) : '0;
    pix = {b0_q, vram_rdata};
`ifdef BSM_FETCH_FLIP_EN
    pix_o = pix;
    for (int i = 0; i < 8; i++) pix_o[2*i +: 2] = hf_q ? pix[14-2*i +: 2] : pix[2*i +: 2];
`else
    pix_o = pix;
`endif
    colour     = pal_q ? clr_q[5:3] : clr_q[2:0];
    vram_we    = cpu_g;
    vram_addr  = cpu_g ? cpu_addr : fetch_addr;
    vram_wdata = rst ? cpu_data : '0;
    vram_re    = owned;
    bsm_we     = state_q == S_WR;
    done       = bsm_we && (c_q == 5'd31) && !line_start;
    busy       = (state_q != S_IDLE) && !done;
    bsm_col    = bsm_we ? c_q : '0;
    bsm_wdata  = bsm_we ? {colour, pix_o} : '0;
  end
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    line_d    = line_q;
    clr_d     = ((state_q == S_TILE) && rd_pend_q) ? vram_rdata[5:0] : clr_q;
    pal_d     = tile_cap ? vram_rdata[7] : pal_q;
    pmba_d    = pmba_v;
    b0_d      = ((state_q == S_PHI) && rd_pend_q) ? vram_rdata : b0_q;
    rd_pend_d = owned & ~line_start;
`ifdef BSM_FETCH_FLIP_EN
    vf_d      = vf_v;
    hf_d      = tile_cap ? vram_rdata[6] : hf_q;
`endif
    if (line_start) begin
      state_d = S_COL;
      c_d     = '0;
      line_d  = line_y;
    end else if (owned) begin
      state_d = (state_q == S_COL)  ? S_TILE :
                (state_q == S_TILE) ? S_PLO  :
                (state_q == S_PLO)  ? S_PHI  : S_WR;
    end else if (state_q == S_WR) begin
      state_d = (c_q == 5'd31) ? S_IDLE : S_TILE;
      c_d     = c_q + 5'd1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      c_q       <= '0;
      line_q    <= '0;
      clr_q     <= '0;
      pal_q     <= 1'b0;
      pmba_q    <= '0;
      b0_q      <= '0;
      rd_pend_q <= 1'b0;
`ifdef BSM_FETCH_FLIP_EN
      vf_q      <= 1'b0;
      hf_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      line_q    <= line_d;
      clr_q     <= clr_d;
      pal_q     <= pal_d;
      pmba_q    <= pmba_d;
      b0_q      <= b0_d;
      rd_pend_q <= rd_pend_d;
`ifdef BSM_FETCH_FLIP_EN
      vf_q      <= vf_d;
      hf_q      <= hf_d;
`endif
    end
  end
endmodule
